// File: rtl/i2c_register_sequencer.sv
// Register-access command sequencer feeding an I2C byte master.
// Turns one read/write command into the per-byte descriptor stream, with address-NACK retry.
module i2c_register_sequencer #(
  parameter int REG_ADDR_BYTES = 1,
  parameter int MAX_LEN        = 16,
  parameter int RETRIES        = 3
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_read,
  input  logic [6:0]  cmd_slave_addr,
  input  logic [15:0] cmd_reg_addr,
  input  logic [7:0]  cmd_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic [1:0]  done_status,
  output logic        transfer_continue,
  output logic        repeated_start,
  output logic        mode,
  output logic [7:0]  data_in,
  input  logic [7:0]  data_rx,
  input  logic        data_rx_enable,
  input  logic        byte_done,
  input  logic        err,
  input  logic        bus_busy
);
  typedef enum logic [2:0] {IDLE, ADDR_W, REG, WDATA, ADDR_R, RDATA, STOP_WAIT, DONE} state_t;

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_NACK_ADDR = 2'd1;
  localparam logic [1:0] ST_NACK_DATA = 2'd2;
  localparam logic [1:0] ST_ABORT     = 2'd3;
  localparam logic [7:0] MAX_LEN_B    = 8'(MAX_LEN);
  localparam logic [3:0] RETRIES_C    = 4'(RETRIES);
  localparam logic [0:0] REG_TOP      = 1'(REG_ADDR_BYTES - 1);

  state_t      state;
  logic        rd_cmd;
  logic [6:0]  slave;
  logic [15:0] reg_addr;
  logic [7:0]  len;
  logic [7:0]  byte_cnt;   // data bytes whose descriptor is not yet loaded
  logic [7:0]  fetch_cnt;  // write bytes still to be taken from the stream
  logic [3:0]  attempts;
  logic [0:0]  reg_idx;
  logic [1:0]  reason;
  logic [7:0]  wbuf;
  logic        wbuf_full;
  logic        abort_pend;
  logic [7:0]  len_clamped;
  logic        take;

  assign len_clamped = (cmd_len > MAX_LEN_B) ? MAX_LEN_B : cmd_len;
  // Single-entry prefetch buffer; the handshake is the pulse itself.
  assign take     = wr_valid && !wbuf_full && (fetch_cnt != 8'd0) && !rd_cmd &&
                    (state == REG || state == WDATA);
  assign wr_ready = take;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      cmd_ready         <= 1'b1;
      rd_cmd            <= 1'b0;
      slave             <= '0;
      reg_addr          <= '0;
      len               <= '0;
      byte_cnt          <= '0;
      fetch_cnt         <= '0;
      attempts          <= '0;
      reg_idx           <= '0;
      reason            <= ST_OK;
      wbuf              <= '0;
      wbuf_full         <= 1'b0;
      abort_pend        <= 1'b0;
      rd_data           <= '0;
      rd_valid          <= 1'b0;
      done              <= 1'b0;
      done_status       <= ST_OK;
      transfer_continue <= 1'b0;
      repeated_start    <= 1'b0;
      mode              <= 1'b0;
      data_in           <= '0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;

      if (take) begin
        wbuf      <= wr_data;
        wbuf_full <= 1'b1;
        fetch_cnt <= fetch_cnt - 8'd1;
      end

      if (state == RDATA && data_rx_enable) begin
        rd_valid <= 1'b1;
        rd_data  <= data_rx;
      end

      if (err && !byte_done && (state == ADDR_W || state == REG || state == WDATA || state == ADDR_R))
        abort_pend <= 1'b1;

      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready         <= 1'b0;
            rd_cmd            <= cmd_read;
            slave             <= cmd_slave_addr;
            reg_addr          <= cmd_reg_addr;
            len               <= len_clamped;
            byte_cnt          <= len_clamped;
            fetch_cnt         <= cmd_read ? 8'd0 : len_clamped;
            attempts          <= '0;
            reason            <= ST_OK;
            wbuf_full         <= 1'b0;
            abort_pend        <= 1'b0;
            data_in           <= {cmd_slave_addr, 1'b0};
            mode              <= 1'b0;
            repeated_start    <= 1'b0;
            transfer_continue <= (cmd_len != 8'd0);
            state             <= ADDR_W;
          end
        end

        ADDR_W: if (byte_done) begin
          if (abort_pend) begin
            transfer_continue <= 1'b0; reason <= ST_ABORT; state <= STOP_WAIT;
          end else if (err) begin
            transfer_continue <= 1'b0; reason <= ST_NACK_ADDR; state <= STOP_WAIT;
          end else if (len == 8'd0) begin
            transfer_continue <= 1'b0; state <= STOP_WAIT;
          end else begin
            reg_idx           <= REG_TOP;
            data_in           <= REG_TOP[0] ? reg_addr[15:8] : reg_addr[7:0];
            transfer_continue <= 1'b1;
            state             <= REG;
          end
        end

        REG: if (byte_done) begin
          if (abort_pend) begin
            transfer_continue <= 1'b0; reason <= ST_ABORT; state <= STOP_WAIT;
          end else if (err) begin
            transfer_continue <= 1'b0; reason <= ST_NACK_DATA; state <= STOP_WAIT;
          end else if (reg_idx != 1'b0) begin
            reg_idx <= 1'b0;
            data_in <= reg_addr[7:0];
          end else if (rd_cmd) begin
            data_in        <= {slave, 1'b1};
            repeated_start <= 1'b1;
            state          <= ADDR_R;
          end else if (wbuf_full) begin
            data_in           <= wbuf;
            wbuf_full         <= 1'b0;
            transfer_continue <= (byte_cnt != 8'd1);
            byte_cnt          <= byte_cnt - 8'd1;
            state             <= WDATA;
          end else begin
            transfer_continue <= 1'b0; reason <= ST_ABORT; state <= STOP_WAIT;
          end
        end

        WDATA: if (byte_done) begin
          if (abort_pend) begin
            transfer_continue <= 1'b0; reason <= ST_ABORT; state <= STOP_WAIT;
          end else if (err) begin
            transfer_continue <= 1'b0; reason <= ST_NACK_DATA; state <= STOP_WAIT;
          end else if (byte_cnt == 8'd0) begin
            state <= STOP_WAIT;
          end else if (wbuf_full) begin
            data_in           <= wbuf;
            wbuf_full         <= 1'b0;
            transfer_continue <= (byte_cnt != 8'd1);
            byte_cnt          <= byte_cnt - 8'd1;
          end else begin
            transfer_continue <= 1'b0; reason <= ST_ABORT; state <= STOP_WAIT;
          end
        end

        ADDR_R: if (byte_done) begin
          if (abort_pend) begin
            transfer_continue <= 1'b0; reason <= ST_ABORT; state <= STOP_WAIT;
          end else if (err) begin
            transfer_continue <= 1'b0; reason <= ST_NACK_ADDR; state <= STOP_WAIT;
          end else begin
            repeated_start    <= 1'b0;
            mode              <= 1'b1;
            transfer_continue <= (byte_cnt != 8'd1);
            byte_cnt          <= byte_cnt - 8'd1;
            state             <= RDATA;
          end
        end

        // err is ignored here: the final NACK is ours, not a failure.
        RDATA: if (byte_done) begin
          if (byte_cnt == 8'd0) begin
            state <= STOP_WAIT;
          end else begin
            transfer_continue <= (byte_cnt != 8'd1);
            byte_cnt          <= byte_cnt - 8'd1;
          end
        end

        STOP_WAIT: if (!bus_busy) begin
          if (reason == ST_NACK_ADDR && attempts < RETRIES_C) begin
            attempts          <= attempts + 4'd1;
            reason            <= ST_OK;
            byte_cnt          <= len;
            fetch_cnt         <= rd_cmd ? 8'd0 : len;
            wbuf_full         <= 1'b0;
            abort_pend        <= 1'b0;
            data_in           <= {slave, 1'b0};
            mode              <= 1'b0;
            repeated_start    <= 1'b0;
            transfer_continue <= (len != 8'd0);
            state             <= ADDR_W;
          end else begin
            state <= DONE;
          end
        end

        DONE: begin
          done        <= 1'b1;
          done_status <= reason;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_register_sequencer.sv
// Bench: table of commands run against two instances (1- and 2-byte register address),
// with a behavioural byte master consuming an expected-descriptor queue.
module tb_i2c_register_sequencer;
  logic clk_in = 1'b0;
  logic reset;
  always #5 clk_in = ~clk_in;

  logic        cmd_valid1, cmd_valid2, cmd_read;
  logic [6:0]  cmd_slave_addr;
  logic [15:0] cmd_reg_addr;
  logic [7:0]  cmd_len, wr_data, data_rx;
  logic        wr_valid, data_rx_enable, byte_done, err, bus_busy;
  logic        sel;

  logic       rdy1, rdy2, wrr1, wrr2, rv1, rv2, dn1, dn2, tc1, tc2, rs1, rs2, md1, md2;
  logic [7:0] rd1, rd2, di1, di2;
  logic [1:0] ds1, ds2;
  logic       c_rdy, c_wrr, c_rv, c_dn, c_tc, c_rs, c_md;
  logic [7:0] c_rd, c_di;
  logic [1:0] c_ds;
  assign {c_rdy, c_wrr, c_rv, c_dn, c_tc, c_rs, c_md, c_rd, c_di, c_ds} = sel ?
         {rdy2, wrr2, rv2, dn2, tc2, rs2, md2, rd2, di2, ds2} :
         {rdy1, wrr1, rv1, dn1, tc1, rs1, md1, rd1, di1, ds1};

  i2c_register_sequencer #(.REG_ADDR_BYTES(1), .MAX_LEN(16), .RETRIES(3)) dut1 (
    .clk_in(clk_in), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(rdy1),
    .cmd_read(cmd_read), .cmd_slave_addr(cmd_slave_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wrr1),
    .rd_data(rd1), .rd_valid(rv1), .done(dn1), .done_status(ds1),
    .transfer_continue(tc1), .repeated_start(rs1), .mode(md1), .data_in(di1),
    .data_rx(data_rx), .data_rx_enable(data_rx_enable), .byte_done(byte_done),
    .err(err), .bus_busy(bus_busy));

  i2c_register_sequencer #(.REG_ADDR_BYTES(2), .MAX_LEN(4), .RETRIES(0)) dut2 (
    .clk_in(clk_in), .reset(reset), .cmd_valid(cmd_valid2), .cmd_ready(rdy2),
    .cmd_read(cmd_read), .cmd_slave_addr(cmd_slave_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wrr2),
    .rd_data(rd2), .rd_valid(rv2), .done(dn2), .done_status(ds2),
    .transfer_continue(tc2), .repeated_start(rs2), .mode(md2), .data_in(di2),
    .data_rx(data_rx), .data_rx_enable(data_rx_enable), .byte_done(byte_done),
    .err(err), .bus_busy(bus_busy));

  typedef struct {
    logic [7:0] data; bit chk; bit tc; bit rs; bit md; bit err; logic [7:0] rx;
  } byte_t;
  // nack: 0 none, 1 every address byte, 2 first register byte
  typedef struct {
    bit d2; bit rd; logic [6:0] addr; logic [15:0] ra; logic [7:0] len;
    int supply; int nack; logic [1:0] status;
  } vec_t;

  byte_t      exp_q[$];
  logic [7:0] rd_q[$];
  int n_chk = 0, n_fail = 0, dn_cnt = 0;
  logic [1:0] dn_stat;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] wpat(int k);
    return (k == 0) ? 8'hA5 : (k == 1) ? 8'h3C : 8'(k * 29 + 3);
  endfunction
  function automatic logic [7:0] rxpat(int k);
    return 8'((k + 1) * 17);
  endfunction
  function automatic byte_t mk(logic [7:0] d, bit chk, bit tc, bit rs, bit md, bit e, logic [7:0] rx);
    byte_t b;
    b.data = d; b.chk = chk; b.tc = tc; b.rs = rs; b.md = md; b.err = e; b.rx = rx;
    return b;
  endfunction

  always @(negedge clk_in) begin
    if (c_rv) begin
      if (rd_q.size() == 0) check("rd_valid_extra", c_rv, 0);
      else check("rd_data", c_rd, rd_q.pop_front());
    end
    if (c_dn) begin dn_cnt++; dn_stat = c_ds; end
  end

  // Expected descriptor stream derived from the protocol description.
  task automatic build(input vec_t v, output int n_wr);
    int regb = v.d2 ? 2 : 1;
    int maxl = v.d2 ? 4 : 16;
    int retr = v.d2 ? 0 : 3;
    int n    = (int'(v.len) > maxl) ? maxl : int'(v.len);
    exp_q.delete(); rd_q.delete(); n_wr = 0;
    if (v.nack == 1) begin
      for (int a = 0; a <= retr; a++) exp_q.push_back(mk({v.addr, 1'b0}, 1, n != 0, 0, 0, 1, 0));
      return;
    end
    exp_q.push_back(mk({v.addr, 1'b0}, 1, n != 0, 0, 0, 0, 0));
    if (n == 0) return;
    for (int i = regb - 1; i >= 0; i--) begin
      exp_q.push_back(mk(8'(v.ra >> (8 * i)), 1, 1, 0, 0, v.nack == 2, 0));
      if (v.nack == 2) return;
    end
    if (v.rd) begin
      exp_q.push_back(mk({v.addr, 1'b1}, 1, 1, 1, 0, 0, 0));
      for (int k = 0; k < n; k++) begin
        exp_q.push_back(mk(0, 0, k != n - 1, 0, 1, 0, rxpat(k)));
        rd_q.push_back(rxpat(k));
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        if (k < v.supply) begin
          exp_q.push_back(mk(wpat(k), 1, k != n - 1, 0, 0, 0, 0));
          n_wr++;
        end else begin
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
          break;
        end
      end
    end
  endtask

  // Behavioural master; returns 1 if it reset the design mid-command.
  task automatic master(input int rst_after, output bit did_rst);
    byte_t e;
    int idx = 0;
    did_rst = 0;
    bus_busy = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      repeat (3) @(negedge clk_in);
      check("transfer_continue", c_tc, e.tc);
      check("repeated_start", c_rs, e.rs);
      check("mode", c_md, e.md);
      if (e.chk) check("data_in", c_di, e.data);
      if (e.md && idx[0]) begin
        data_rx = e.rx; data_rx_enable = 1;
        @(negedge clk_in); data_rx_enable = 0;
      end
      byte_done = 1; err = e.err;
      if (e.md && !idx[0]) begin data_rx = e.rx; data_rx_enable = 1; end
      @(negedge clk_in);
      byte_done = 0; err = 0; data_rx_enable = 0;
      if (idx == rst_after) begin
        #2 reset = 1; #1;
        check("reset_mid_rdata", {c_rdy, c_tc, c_rs, c_md, c_di, c_dn, c_ds, c_rv, c_wrr}, 17'h10000);
        @(negedge clk_in); reset = 0; bus_busy = 0;
        exp_q.delete(); rd_q.delete();
        did_rst = 1;
        return;
      end
      if (!e.tc || e.err) begin
        repeat (3) @(negedge clk_in); bus_busy = 0;
        if (exp_q.size() > 0) begin repeat (3) @(negedge clk_in); bus_busy = 1; end
      end
      idx++;
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_in);
      if (c_dn) break;
    end
    check("done_pulse", c_dn, 1);
    check("cmd_ready_during_done", c_rdy, 0);
    @(negedge clk_in);
    check("cmd_ready_after_done", c_rdy, 1);
  endtask

  task automatic run_cmd(input vec_t v, input int rst_after);
    int  n_wr;
    int  wr_taken = 0;
    bit  fin = 0;
    bit  did_rst;
    build(v, n_wr);
    sel = v.d2; dn_cnt = 0;
    @(negedge clk_in);
    check("cmd_ready_idle", c_rdy, 1);
    cmd_read = v.rd; cmd_slave_addr = v.addr; cmd_reg_addr = v.ra; cmd_len = v.len;
    if (v.d2) cmd_valid2 = 1; else cmd_valid1 = 1;
    @(posedge clk_in); #1;
    cmd_valid1 = 0; cmd_valid2 = 0;
    fork
      begin
        int k = 0;
        wr_data = wpat(0); wr_valid = (v.supply > 0);
        for (int c = 0; c < 3000 && !fin && k < v.supply; c++) begin
          @(negedge clk_in);
          if (wr_valid && c_wrr) begin
            wr_taken++;
            @(posedge clk_in); #1;
            k++; wr_data = wpat(k); wr_valid = (k < v.supply);
          end
        end
        wr_valid = 0;
      end
      begin
        master(rst_after, did_rst);
        fin = 1;
      end
    join
    if (!did_rst) begin
      check("done_count", dn_cnt, 1);
      check("done_status", dn_stat, v.status);
      check("wr_ready_count", wr_taken, n_wr);
      check("rd_bytes_missing", rd_q.size(), 0);
    end else begin
      check("no_done_after_reset", dn_cnt, 0);
    end
  endtask

  vec_t vecs[10];
  vec_t rvec;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; sel = 0;
    cmd_valid1 = 0; cmd_valid2 = 0; cmd_read = 0; cmd_slave_addr = 0; cmd_reg_addr = 0;
    cmd_len = 0; wr_data = 0; wr_valid = 0; data_rx = 0; data_rx_enable = 0;
    byte_done = 0; err = 0; bus_busy = 0;
    vecs[0] = '{0, 0, 7'h50, 16'h0010, 8'd2,  2, 0, 2'd0}; // write A5,3C
    vecs[1] = '{0, 1, 7'h50, 16'h0010, 8'd3,  0, 0, 2'd0}; // read 11,22,33
    vecs[2] = '{0, 0, 7'h50, 16'h0010, 8'd3,  0, 1, 2'd1}; // 4 address NACKs
    vecs[3] = '{0, 0, 7'h50, 16'h0010, 8'd3,  1, 0, 2'd3}; // underflow
    vecs[4] = '{0, 0, 7'h3C, 16'h0000, 8'd0,  0, 0, 2'd0}; // probe
    vecs[5] = '{0, 0, 7'h50, 16'h0022, 8'd1,  0, 2, 2'd2}; // register byte NACK
    vecs[6] = '{0, 1, 7'h21, 16'h0005, 8'd20, 0, 0, 2'd0}; // clamp to 16
    vecs[7] = '{1, 0, 7'h50, 16'hABCD, 8'd1,  1, 0, 2'd0}; // 2-byte register, MSB first
    vecs[8] = '{1, 1, 7'h50, 16'hABCD, 8'd9,  0, 0, 2'd0}; // clamp to 4
    vecs[9] = '{1, 1, 7'h2A, 16'h0001, 8'd2,  0, 1, 2'd1}; // zero retries
    rvec    = '{0, 1, 7'h50, 16'h0010, 8'd3,  0, 0, 2'd0};
    #12;
    check("reset_state_dut1", {rdy1, tc1, rs1, md1, di1, dn1, ds1, rv1, wrr1}, 17'h10000);
    check("reset_state_dut2", {rdy2, tc2, rs2, md2, di2, dn2, ds2, rv2, wrr2}, 17'h10000);
    @(negedge clk_in); reset = 0;
    for (int i = 0; i < 10; i++) run_cmd(vecs[i], -1);
    run_cmd(rvec, 3);
    run_cmd(vecs[0], -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_register_sequencer.md
Name: i2c_register_sequencer

Overview:
Command-level front end that sits directly upstream of the I2C byte master. It turns one register-access command into a master byte sequence:
- write: START, address+W, register-address bytes, data bytes, STOP;
- read: START, address+W, register-address bytes, repeated START, address+R, data bytes, STOP.

It drives the master's per-byte descriptor (transfer_continue, mode, data_in, repeated_start) and consumes the master's byte-completion, receive-data and error outputs. Address NACKs are retried; results are reported to the user.

Parameters:
REG_ADDR_BYTES, 1, register-address bytes sent MSB first (1 or 2)
MAX_LEN, 16, maximum data bytes per command (1..255)
RETRIES, 3, extra attempts after an address-byte NACK (0..15)

Ports:
clk_in  input  1  system clock, same clock as the master
reset  input  1  asynchronous, active-high
cmd_valid  input  1  command request
cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid&&cmd_ready
cmd_read  input  1  0 = write, 1 = read
cmd_slave_addr  input  7  7-bit slave address
cmd_reg_addr  input  16  register address; low REG_ADDR_BYTES*8 bits used
cmd_len  input  8  data byte count; 0 = address-only probe; values >MAX_LEN clamp to MAX_LEN
wr_data  input  8  write payload stream
wr_valid  input  1  wr_data valid
wr_ready  output  1  one-cycle pulse when wr_data is taken
rd_data  output  8  received byte
rd_valid  output  1  one-cycle pulse per received byte; no backpressure
done  output  1  one-cycle pulse at command completion
done_status  output  2  0 OK, 1 address NACK after retries, 2 data NACK, 3 write underflow/bus error; valid with done
transfer_continue  output  1  to master: 1 = another byte follows, 0 = STOP after current byte
repeated_start  output  1  to master: issue repeated START before the next byte
mode  output  1  to master: 0 = transmit next byte, 1 = receive
data_in  output  8  to master: next transmit byte
data_rx  input  8  from master: received byte
data_rx_enable  input  1  from master: data_rx valid, one cycle
byte_done  input  1  from master: pulse at the end of each byte's ACK slot
err  input  1  from master: NACK/arbitration for the current byte, valid with byte_done
bus_busy  input  1  from master: bus between START and STOP

Behaviour:
Reset values:
- cmd_ready=1; all strobes (wr_ready, rd_valid, done) = 0; transfer_continue=0; repeated_start=0; mode=0; data_in=0; done_status=0; state=IDLE.
- Reset mid-transfer: all of the above apply immediately. The master's STOP is not waited for.

Descriptor timing:
- Descriptor outputs are registered.
- They update exactly one clk_in cycle after byte_done, or one cycle after command accept for the first byte.
- They are held stable otherwise.

States:
- IDLE: on accept, latch all cmd_* fields; attempt counter=0; load descriptor for ADDR_W: data_in={addr,0}, mode=0, transfer_continue=1.
- ADDR_W: on byte_done.
  - err: go to STOP_WAIT with transfer_continue=0, reason=NACK_ADDR.
  - else: go to REG.
  - Probe (len=0): load transfer_continue=0; the STOP follows, then DONE OK.
- REG: send REG_ADDR_BYTES bytes, MSB first.
  - After the last byte, write commands go to WDATA and read commands go to ADDR_R.
  - ADDR_R descriptor: repeated_start=1, data_in={addr,1}.
  - err on any REG byte: reason=NACK_DATA.
- WDATA: each byte_done without err consumes one prefetched byte.
  - The byte for the next slot must be buffered (wr_valid&&wr_ready) before the current byte_done. Prefetch may occur any time after entering REG.
  - If the buffer is empty when the descriptor must be loaded: transfer_continue=0, reason=UNDERFLOW.
  - Last byte carries transfer_continue=0.
- ADDR_R: err leads to reason=NACK_ADDR; otherwise go to RDATA with mode=1, and repeated_start is cleared.
- RDATA: each data_rx_enable pulses rd_valid with rd_data=data_rx the next cycle.
  - transfer_continue=1 while more bytes remain, so the master ACKs.
  - transfer_continue=0 for the final byte, so the master NACKs and stops.
  - err is ignored in RDATA.
- STOP_WAIT: wait for bus_busy=0.
  - If reason=NACK_ADDR and attempts<RETRIES: increment attempts and restart at ADDR_W (full sequence).
  - Otherwise go to DONE.
- DONE: pulse done with done_status; go to IDLE. cmd_ready returns the following cycle.

Simultaneous events:
- byte_done together with data_rx_enable: both are processed in the same cycle.
- err at any other point: abort, reason=3, at the next byte_done.

Counters:
- Byte counter is 8-bit and counts down; no wrap (clamped length).
- Retry counter is 4-bit and saturating.

Test Plan:
1. REG_ADDR_BYTES=1; write slave 0x50, reg 0x10, len 2, data A5,3C, all ACK -> data_in sequence A0,10,A5,3C; transfer_continue 1,1,1,0; two wr_ready pulses; done with status 0.
2. Read 0x50, reg 0x10, len 3, bytes 11,22,33 -> A0,10 then repeated_start=1 with A1; three rd_valid pulses 11,22,33; transfer_continue 0 on third byte; status 0.
3. Address NACK on every attempt, RETRIES=3 -> 4 ADDR_W attempts, each followed by a STOP_WAIT until bus_busy=0; done with status 1.
4. Write len 3 with wr_valid withheld after the first byte -> second data slot gets transfer_continue=0; status 3; no third wr_ready.
5. len=0 probe to 0x3C, ACK -> single byte 78 with transfer_continue=0; status 0. REG_ADDR_BYTES=2 write to reg 0xABCD -> AB sent before CD.
6. Assert reset during RDATA -> next cycle all outputs at reset values, cmd_ready=1; a fresh command then completes normally.
